// File: rtl/rand_stall_sink.sv
// Val/rdy message sink that checks each message against the expected-data array mem and
// throttles its rdy output with an LFSR so the upstream source sees pseudo-random stalls.
module rand_stall_sink #(
  parameter int unsigned p_width        = 16,
  parameter int unsigned p_nmsgs        = 100,
  parameter logic [15:0] p_seed         = 16'hACE1,
  parameter int unsigned p_stall_thresh = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               val,
  output logic               rdy,
  input  logic [p_width-1:0] msg,
  output logic               done,
  output logic               err,
  output logic [15:0]        err_count,
  output logic [15:0]        first_err_idx
);

  localparam int unsigned IdxW     = (p_nmsgs > 0) ? $clog2(p_nmsgs + 1) : 1;
  localparam int unsigned MemDepth = (p_nmsgs > 0) ? p_nmsgs : 1;
  localparam logic [15:0] SeedEff  = (p_seed == 16'h0000) ? 16'h0001 : p_seed;
  localparam logic [15:0] Taps     = 16'hB400;
  // Nine bits so that a threshold of 256 stalls on every LFSR value.
  localparam logic [8:0]  StallThresh = 9'(p_stall_thresh);
  localparam logic [IdxW-1:0] NumMsgs = IdxW'(p_nmsgs);

  // Expected messages; filled from outside before reset deasserts.
  logic [p_width-1:0] mem [MemDepth];

  logic [IdxW-1:0] idx_q, idx_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            err_q, err_d;
  logic [15:0]     err_count_q, err_count_d;
  logic [15:0]     first_err_idx_q, first_err_idx_d;
  logic            stall;
  logic            xfer;
  logic            mismatch;

  always_comb begin
    stall    = ({1'b0, lfsr_q[7:0]} < StallThresh);
    done     = (idx_q == NumMsgs);
    rdy      = !reset && !done && !stall;
    xfer     = val && rdy;
    mismatch = xfer && (msg != mem[idx_q]);
  end

  always_comb begin
    idx_d           = idx_q;
    err_d           = err_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    lfsr_d          = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? Taps : 16'h0000);
    if (xfer) begin
      idx_d = idx_q + 1'b1;
    end
    if (mismatch) begin
      err_d = 1'b1;
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
      if (!err_q) begin
        first_err_idx_d = 16'(idx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q           <= '0;
      lfsr_q          <= SeedEff;
      err_q           <= 1'b0;
      err_count_q     <= 16'h0000;
      first_err_idx_q <= 16'h0000;
    end else begin
      idx_q           <= idx_d;
      lfsr_q          <= lfsr_d;
      err_q           <= err_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign err           = err_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_rand_stall_sink.sv
// Bench for rand_stall_sink: three sinks (never/half/always stall) checked every cycle against
// a transaction-level model, plus literal expectations from the directed scenarios.
module tb_rand_stall_sink;

  localparam int N = 100;
  localparam logic [15:0] Seed = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst = 3'b111;
  logic [2:0]  val = 3'b000;
  logic [2:0]  rdy, done, err;
  logic [15:0] msg [3];
  logic [15:0] ec [3];
  logic [15:0] fe [3];

  int thr [3] = '{0, 128, 256};
  int mode [3] = '{0, 0, 0};

  int n_checks = 0;
  int n_pass = 0;

  rand_stall_sink #(.p_width(16), .p_nmsgs(N), .p_seed(Seed), .p_stall_thresh(0)) u0 (
    .clk(clk), .reset(rst[0]), .val(val[0]), .rdy(rdy[0]), .msg(msg[0]), .done(done[0]),
    .err(err[0]), .err_count(ec[0]), .first_err_idx(fe[0])
  );
  rand_stall_sink #(.p_width(16), .p_nmsgs(N), .p_seed(Seed), .p_stall_thresh(128)) u1 (
    .clk(clk), .reset(rst[1]), .val(val[1]), .rdy(rdy[1]), .msg(msg[1]), .done(done[1]),
    .err(err[1]), .err_count(ec[1]), .first_err_idx(fe[1])
  );
  rand_stall_sink #(.p_width(16), .p_nmsgs(N), .p_seed(Seed), .p_stall_thresh(256)) u2 (
    .clk(clk), .reset(rst[2]), .val(val[2]), .rdy(rdy[2]), .msg(msg[2]), .done(done[2]),
    .err(err[2]), .err_count(ec[2]), .first_err_idx(fe[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Transaction-level model: messages received so far, error bookkeeping, reference LFSR.
  int          m_idx [3];
  logic [15:0] m_lfsr [3];
  logic        m_err [3];
  int          m_cnt [3];
  int          m_first [3];
  logic        started [3] = '{1'b0, 1'b0, 1'b0};

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic model_rdy(input int k);
    return !rst[k] && (m_idx[k] < N) && (int'(m_lfsr[k][7:0]) >= thr[k]);
  endfunction

  function automatic logic [15:0] src_data(input int md, input int p);
    if (md == 2) return 16'h1234;
    if (md == 1 && p == 17) return 16'hDEAD;
    if (md == 1 && p == 42) return 16'hBEEF;
    return 16'(p);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        m_idx[k] = 0; m_lfsr[k] = Seed; m_err[k] = 1'b0; m_cnt[k] = 0; m_first[k] = 0;
      end else begin
        if (val[k] && model_rdy(k)) begin
          if (msg[k] != 16'(m_idx[k])) begin
            $display("sink %0d: mismatch at index %0d, expected %0h, received %0h",
                     k, m_idx[k], 16'(m_idx[k]), msg[k]);
            if (!m_err[k]) m_first[k] = m_idx[k];
            m_err[k] = 1'b1;
            if (m_cnt[k] < 65535) m_cnt[k]++;
          end
          m_idx[k]++;
        end
        m_lfsr[k] = lfsr_next(m_lfsr[k]);
      end
      started[k] = 1'b1;
    end
  end

  // Source: presents the message for the next unsent index shortly after each edge.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) msg[k] = src_data(mode[k], m_idx[k]);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (started[k]) begin
        check($sformatf("s%0d rdy", k), 32'(rdy[k]), 32'(model_rdy(k)));
        check($sformatf("s%0d done", k), 32'(done[k]), 32'(m_idx[k] == N));
        check($sformatf("s%0d err", k), 32'(err[k]), 32'(m_err[k]));
        check($sformatf("s%0d err_count", k), 32'(ec[k]), 32'(m_cnt[k]));
        if (m_err[k]) check($sformatf("s%0d first_err_idx", k), 32'(fe[k]), 32'(m_first[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idx(input int k, input int target, input int budget);
    int n;
    n = 0;
    while (m_idx[k] != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("s%0d reach idx %0d", k, target), 32'(m_idx[k]), 32'(target));
  endtask

  task automatic wait_done(input int k, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done[k] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("s%0d done within budget", k), 32'(done[k]), 32'd1);
  endtask

  initial begin
    int rdy_seen, cyc, first_x, done_cyc;
    bit exp_rdy [4];
    for (int k = 0; k < 3; k++) msg[k] = 16'h0000;
    for (int i = 0; i < N; i++) begin
      u0.mem[i] = 16'(i);
      u1.mem[i] = 16'(i);
      u2.mem[i] = 16'(i);
    end
    repeat (3) step();

    // Always-stall sink never becomes ready.
    rst[2] = 1'b0;
    val[2] = 1'b1;
    rdy_seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rdy[2]) rdy_seen++;
    end
    check("s2 rdy cycles over 1000", 32'(rdy_seen), 32'd0);
    check("s2 done after 1000", 32'(done[2]), 32'd0);
    step();
    val[2] = 1'b0;

    // Never-stall sink: back-to-back transfers, done exactly 100 cycles after the first.
    rst[0] = 1'b0;
    val[0] = 1'b1;
    cyc = 0; first_x = -1; done_cyc = -1;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (first_x < 0 && val[0] && rdy[0]) first_x = cyc;
      if (done[0]) done_cyc = cyc;
    end
    check("s0 done latency", 32'(done_cyc - first_x), 32'd100);
    check("s0 err clean", 32'(err[0]), 32'd0);
    check("s0 err_count clean", 32'(ec[0]), 32'd0);

    // Reset after 50 transfers, then the whole sequence again.
    step(); rst[0] = 1'b1;
    step(); rst[0] = 1'b0;
    wait_idx(0, 50, 200);
    step(); rst[0] = 1'b1;
    @(negedge clk);
    check("s0 rdy in reset", 32'(rdy[0]), 32'd0);
    check("s0 done in reset", 32'(done[0]), 32'd0);
    step(); rst[0] = 1'b0;
    wait_done(0, 300);
    check("s0 restart err", 32'(err[0]), 32'd0);
    check("s0 restart err_count", 32'(ec[0]), 32'd0);

    // Corrupted messages 17 and 42.
    step(); rst[0] = 1'b1; mode[0] = 1;
    step(); rst[0] = 1'b0;
    wait_idx(0, 17, 200);
    check("s0 err before idx17", 32'(err[0]), 32'd0);
    wait_idx(0, 18, 10);
    check("s0 err after idx17", 32'(err[0]), 32'd1);
    check("s0 first_err after idx17", 32'(fe[0]), 32'd17);
    check("s0 err_count after idx17", 32'(ec[0]), 32'd1);
    wait_done(0, 300);
    check("s0 err at done", 32'(err[0]), 32'd1);
    check("s0 err_count at done", 32'(ec[0]), 32'd2);
    check("s0 first_err at done", 32'(fe[0]), 32'd17);

    // Wrong message offered after completion is ignored.
    step(); mode[0] = 2; val[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("s0 post-done rdy", 32'(rdy[0]), 32'd0);
      check("s0 post-done done", 32'(done[0]), 32'd1);
      check("s0 post-done err_count", 32'(ec[0]), 32'd2);
    end
    step(); val[0] = 1'b0;

    // Half-stall sink: first rdy values from seed ACE1 -> E270 -> 7138 -> 389C.
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst[1] = 1'b0;
    val[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("s1 rdy cycle %0d", i), 32'(rdy[1]), 32'(exp_rdy[i]));
    end
    wait_done(1, 2000);
    check("s1 err", 32'(err[1]), 32'd0);
    check("s1 err_count", 32'(ec[1]), 32'd0);
    step(); val[1] = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
